// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_ctrl
//  Purpose  : Run-control sequencer for a WIDTH-bit counter datapath. Takes a
//             configuration (limit, direction, one-shot/periodic) over a
//             valid/ready handshake, then steps the count through an
//             IDLE/ARMED/RUN/PAUSE/DONE state machine. It reports a
//             terminal-count strobe and a saturating count of periodic reloads.
//  Optional : CTR_PRESCALE_EN adds parameter PRE_W and port cfg_prescale.
//             When it is defined, a step occurs once every cfg_prescale+1
//             RUN cycles.
//  Ports    : clk        - clock, all state changes on posedge
//             reset      - synchronous, active-low reset
//             cfg_valid  - configuration offer
//             cfg_ready  - configuration accept window (IDLE/ARMED/DONE)
//             cfg_limit  - terminal value, period is cfg_limit+1 steps
//             cfg_dir    - 0 = up 0..limit, 1 = down limit..0
//             cfg_mode   - 0 = one-shot, 1 = periodic
//             cfg_prescale (CTR_PRESCALE_EN only) - step divider minus one
//             start      - run/resume request (level)
//             stop       - pause request (level), has priority over start
//             count      - current count value
//             tc         - terminal-count strobe (combinational)
//             busy       - high in RUN or PAUSE
//             done       - high in DONE
//             wrap_cnt   - number of periodic reloads, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
`ifdef CTR_PRESCALE_EN
   ,
   parameter int PRE_W  = 8
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH-1:0]  cfg_limit,
   input  logic              cfg_dir,
   input  logic              cfg_mode,
`ifdef CTR_PRESCALE_EN
   input  logic [PRE_W-1:0]  cfg_prescale,
`endif
   input  logic              start,
   input  logic              stop,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              busy,
   output logic              done,
   output logic [WRAP_W-1:0] wrap_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    count_q, count_d;
   logic [WIDTH-1:0]    limit_q, limit_d;
   logic                dir_q, dir_d;
   logic                mode_q, mode_d;
   logic [WRAP_W-1:0]   wrap_q, wrap_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;

   logic                xfer;
   logic                tick;
   logic                step;
   logic                at_term;
   logic [WIDTH-1:0]    start_val;
   logic [WIDTH-1:0]    term_val;

`ifdef CTR_PRESCALE_EN
   logic [PRE_W-1:0]    pre_cfg_q, pre_cfg_d;
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;

   assign tick = (pre_cnt_q == pre_cfg_q);
`else
   assign tick = 1'b1;
`endif

   // The handshake window is the registered ready, so an offer during RUN or
   // PAUSE is simply dropped.
   assign xfer      = cfg_valid && ready_q;
   assign start_val = dir_q ? limit_q : '0;
   assign term_val  = dir_q ? '0 : limit_q;
   assign at_term   = (count_q == term_val);
   assign step      = (state_q == ST_RUN) && !stop && tick;
   assign tc        = step && at_term;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      wrap_d  = wrap_q;
`ifdef CTR_PRESCALE_EN
      pre_cfg_d = pre_cfg_q;
      pre_cnt_d = pre_cnt_q;
`endif

      case (state_q)
         ST_IDLE, ST_ARMED, ST_DONE: begin
            if (xfer) begin
               // A transfer wins over start; ARMED re-arms with the new values.
               limit_d = cfg_limit;
               dir_d   = cfg_dir;
               mode_d  = cfg_mode;
               count_d = cfg_dir ? cfg_limit : '0;
               wrap_d  = '0;
               state_d = ST_ARMED;
`ifdef CTR_PRESCALE_EN
               pre_cfg_d = cfg_prescale;
`endif
            end else if (state_q != ST_IDLE && start && !stop) begin
               // DONE restarts from the start value; ARMED is already preloaded.
               if (state_q == ST_DONE) begin
                  count_d = start_val;
               end
               state_d = ST_RUN;
`ifdef CTR_PRESCALE_EN
               pre_cnt_d = '0;
`endif
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_PAUSE;
            end else begin
`ifdef CTR_PRESCALE_EN
               pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
`endif
               if (step) begin
                  if (!at_term) begin
                     count_d = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
                  end else if (mode_q) begin
                     count_d = start_val;
                     if (wrap_q != '1) begin
                        wrap_d = wrap_q + WRAP_W'(1);
                     end
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
         end

         ST_PAUSE: begin
            // Prescaler phase is held here so a resume continues mid-period.
            if (start && !stop) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done_d  = (state_d == ST_DONE);
      ready_d = !busy_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         limit_q <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         wrap_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
`ifdef CTR_PRESCALE_EN
         pre_cfg_q <= '0;
         pre_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
`ifdef CTR_PRESCALE_EN
         pre_cfg_q <= pre_cfg_d;
         pre_cnt_q <= pre_cnt_d;
`endif
      end
   end

   assign count     = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_ready = ready_q;
   assign wrap_cnt  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_seq_ctrl
//  Purpose  : Self-checking bench for counter_seq_ctrl: a table of directed
//             vectors, hand-written multi-cycle sequences, and random stimulus
//             compared with a position-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_limit;
   logic       cfg_dir;
   logic       cfg_mode;
   logic       start;
   logic       stop;
   logic [3:0] count;
   logic       tc;
   logic       busy;
   logic       done;
   logic [7:0] wrap_cnt;
`ifdef CTR_PRESCALE_EN
   logic [7:0] cfg_prescale;
`endif

   counter_seq_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_limit (cfg_limit),
      .cfg_dir   (cfg_dir),
      .cfg_mode  (cfg_mode),
`ifdef CTR_PRESCALE_EN
      .cfg_prescale (cfg_prescale),
`endif
      .start     (start),
      .stop      (stop),
      .count     (count),
      .tc        (tc),
      .busy      (busy),
      .done      (done),
      .wrap_cnt  (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   // Reference model: phase plus distance travelled from the start value.
   // 0 idle, 1 armed, 2 running, 3 paused, 4 finished.
   int m_ph = 0, m_lim = 0, m_dir = 0, m_mode = 0, m_pos = 0, m_wrap = 0;

   function automatic int m_count();
      return m_dir ? (m_lim - m_pos) : m_pos;
   endfunction

   function automatic int m_tc(input bit st_i, input bit sp_i);
      return (m_ph == 2 && !sp_i && m_pos == m_lim) ? 1 : 0;
   endfunction

   task automatic m_update(input bit rn, input bit cv, input int lim, input bit d,
                           input bit md, input bit st_i, input bit sp_i);
      bit go;
      go = st_i && !sp_i;
      if (!rn) begin
         m_ph = 0; m_lim = 0; m_dir = 0; m_mode = 0; m_pos = 0; m_wrap = 0;
      end else if (cv && (m_ph == 0 || m_ph == 1 || m_ph == 4)) begin
         m_ph = 1; m_lim = lim; m_dir = d; m_mode = md; m_pos = 0; m_wrap = 0;
      end else if (m_ph == 1 && go) begin
         m_ph = 2;
      end else if (m_ph == 4 && go) begin
         m_ph = 2; m_pos = 0;
      end else if (m_ph == 3 && go) begin
         m_ph = 2;
      end else if (m_ph == 2) begin
         if (sp_i) m_ph = 3;
         else if (m_pos < m_lim) m_pos = m_pos + 1;
         else if (m_mode) begin
            m_pos = 0;
            if (m_wrap < 255) m_wrap = m_wrap + 1;
         end else m_ph = 4;
      end
   endtask

   int got_tc;

   // One clock cycle: drive at negedge, sample tc before the edge, update the
   // model at the edge, then optionally compare everything against it.
   task automatic do_cycle(input bit rn, input bit cv, input int lim, input bit d,
                           input bit md, input bit st_i, input bit sp_i, input bit cm);
      @(negedge clk);
      reset = rn; cfg_valid = cv; cfg_limit = lim[3:0]; cfg_dir = d;
      cfg_mode = md; start = st_i; stop = sp_i;
      #1;
      got_tc = int'(tc);
      if (cm) chk("tc", got_tc, m_tc(st_i, sp_i));
      @(posedge clk);
      m_update(rn, cv, lim, d, md, st_i, sp_i);
      #1;
      if (cm) begin
         chk("count", int'(count), m_count());
         chk("busy", int'(busy), (m_ph == 2 || m_ph == 3) ? 1 : 0);
         chk("done", int'(done), (m_ph == 4) ? 1 : 0);
         chk("cfg_ready", int'(cfg_ready), (m_ph == 0 || m_ph == 1 || m_ph == 4) ? 1 : 0);
         chk("wrap_cnt", int'(wrap_cnt), m_wrap);
      end
   endtask

   typedef struct {
      bit rn; bit cv; int lim; bit d; bit md; bit st; bit sp;
      int e_tc; int e_cnt; int e_busy; int e_done; int e_rdy; int e_wrap;
   } vec_t;

   vec_t tbl[17];

   initial begin
      reset = 1'b0; cfg_valid = 1'b0; cfg_limit = '0; cfg_dir = 1'b0;
      cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef CTR_PRESCALE_EN
      cfg_prescale = '0;
`endif

      //           rn cv lim d md st sp | tc cnt busy done rdy wrap
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0};
      tbl[2]  = '{1, 1, 5, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0};
      tbl[3]  = '{1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0};
      tbl[5]  = '{1, 0, 0, 0, 0, 0, 0,   0, 2, 1, 0, 0, 0};
      tbl[6]  = '{1, 0, 0, 0, 0, 0, 0,   0, 3, 1, 0, 0, 0};
      tbl[7]  = '{1, 0, 0, 0, 0, 0, 0,   0, 4, 1, 0, 0, 0};
      tbl[8]  = '{1, 0, 0, 0, 0, 0, 0,   0, 5, 1, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1};
      tbl[10] = '{1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1};
      tbl[11] = '{1, 0, 0, 0, 0, 1, 1,   0, 1, 1, 0, 0, 1};
      tbl[12] = '{1, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0, 1};
      tbl[13] = '{1, 0, 0, 0, 0, 0, 0,   0, 2, 1, 0, 0, 1};
      tbl[14] = '{1, 1, 3, 1, 0, 0, 0,   0, 3, 1, 0, 0, 1};
      tbl[15] = '{1, 0, 0, 0, 0, 0, 1,   0, 3, 1, 0, 0, 1};
      tbl[16] = '{1, 0, 0, 0, 0, 0, 0,   0, 3, 1, 0, 0, 1};

      for (int i = 0; i < 17; i++) begin
         do_cycle(tbl[i].rn, tbl[i].cv, tbl[i].lim, tbl[i].d, tbl[i].md,
                  tbl[i].st, tbl[i].sp, 1'b0);
         chk($sformatf("tbl%0d.tc", i), got_tc, tbl[i].e_tc);
         chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].e_cnt);
         chk($sformatf("tbl%0d.busy", i), int'(busy), tbl[i].e_busy);
         chk($sformatf("tbl%0d.done", i), int'(done), tbl[i].e_done);
         chk($sformatf("tbl%0d.cfg_ready", i), int'(cfg_ready), tbl[i].e_rdy);
         chk($sformatf("tbl%0d.wrap_cnt", i), int'(wrap_cnt), tbl[i].e_wrap);
      end

      // One-shot down with a 4-cycle pause, then finish and restart from DONE.
      do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
      do_cycle(1, 1, 3, 1, 0, 0, 0, 1);
      chk("os.armed_count", int'(count), 3);
      do_cycle(1, 0, 0, 0, 0, 1, 0, 1);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
      chk("os.first_step", int'(count), 2);
      for (int i = 0; i < 4; i++) begin
         do_cycle(1, 0, 0, 0, 0, 0, 1, 1);
         chk("os.pause_tc", got_tc, 0);
         chk("os.pause_hold", int'(count), 2);
      end
      do_cycle(1, 0, 0, 0, 0, 1, 0, 1);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
      chk("os.reach_zero", int'(count), 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
      chk("os.final_tc", got_tc, 1);
      chk("os.done", int'(done), 1);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
      chk("os.hold_after_done", int'(count), 0);
      do_cycle(1, 0, 0, 0, 0, 1, 0, 1);
      chk("os.restart_count", int'(count), 3);

      // limit=0 periodic: tc on every RUN cycle, wrap count saturates.
      do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
      do_cycle(1, 1, 0, 0, 1, 0, 0, 1);
      do_cycle(1, 0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 300; i++) begin
         do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
         if (i < 5) chk("lim0.tc", got_tc, 1);
      end
      chk("lim0.wrap_sat", int'(wrap_cnt), 255);

      // Reset while running at count 4; a following start must be ignored.
      do_cycle(1, 0, 0, 0, 0, 0, 1, 1);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
      do_cycle(1, 1, 9, 0, 0, 0, 0, 1);
      do_cycle(1, 0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, 0, 0, 0, 0, 1);
      chk("rst.pre_count", int'(count), 4);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst.tc", got_tc, 0);
      chk("rst.count", int'(count), 0);
      chk("rst.busy", int'(busy), 0);
      do_cycle(1, 0, 0, 0, 0, 1, 0, 1);
      chk("rst.idle_start", int'(busy), 0);

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         do_cycle(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 99) < 20),
                  int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 15),
                  1'b1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
